barrel_shifter_pipe: RTL and testbench
======================================

Name: barrel_shifter_pipe

Overview:
- Parametrised, pipelined barrel shifter with four shift modes: logical left, logical right, arithmetic right and rotate left.
- Uses one registered stage per shift-amount bit and valid/ready handshakes on both sides, with per-stage backpressure.
- Serves as the shift unit in ALU datapaths where operand width is a parameter and timing requires one shift level per cycle.

Parameters:
- WIDTH, 8, data width in bits. Must be a power of two and at least 2.
- SHW, $clog2(WIDTH), derived localparam, not overridable. It is the shift-amount width and the pipeline depth.

Ports:
- i_clk  input  1  clock. All state updates on the rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_valid  input  1  upstream operand valid.
- o_ready  output  1  block can accept an operand this cycle.
- i_in  input  WIDTH  operand.
- i_shamt  input  SHW  shift amount, 0..WIDTH-1.
- i_mode  input  2  shift mode: 00 SLL, 01 SRL, 10 SRA, 11 ROL.
- o_valid  output  1  result valid.
- i_ready  input  1  downstream accepts result.
- o_out  output  WIDTH  shifted result.
- o_zero  output  1  o_out equals all zeros. Qualified by o_valid.

Behaviour:
- Transfers:
  - An operand transfer occurs on a cycle where i_valid and o_ready are both high.
  - A result transfer occurs on a cycle where o_valid and i_ready are both high.
- Pipeline structure:
  - SHW stages, numbered 0..SHW-1.
  - Each stage register holds valid, data, remaining shamt, mode and its zero flag.
- Stage k operation:
  - If shamt bit k is set, stage k shifts its input by 2^k using the carried mode. Otherwise it passes the data through unchanged.
  - Stage 0 takes its input from i_in, i_shamt and i_mode.
- Mode rules at each stage:
  - SLL fills with zeros at the LSB end.
  - SRL fills with zeros at the MSB end.
  - SRA fills with the current MSB. Successive arithmetic shifts compose to the original sign.
  - ROL moves bits shifted out of the MSB end into the LSB end.
- The final stage computes o_zero as the NOR of its shifted data and registers it alongside the data.
- Latency: an operand accepted in cycle t appears on o_out/o_valid in cycle t+SHW, provided there is no backpressure.
- Throughput: one operand per cycle while i_ready stays high.
- Per-stage flow control:
  - Stage k loads when it is empty or stage k+1 loads / drains in the same cycle.
  - The last stage drains when i_ready is high.
  - o_ready equals stage 0's load condition, gated low while i_reset is high.
- Bubble collapse: an empty stage ahead of a stalled stage still loads, so capacity is SHW operands.
- Stalls:
  - A stalled stage holds its contents unchanged.
  - o_out, o_zero and o_valid stay stable while o_valid is high and i_ready is low.
- Ordering: results leave in acceptance order. There is no reordering and no drops.
- i_shamt = 0 in any mode: output equals the input.
- i_in, i_shamt and i_mode are ignored when no operand transfer occurs.
- Reset values: all stage valid bits 0, all data 0. Therefore o_valid = 0, o_out = 0, o_zero = 0.
  - o_zero resets to 0 even though o_out is 0, because it is registered.
- Reset mid-operation: all in-flight operands are discarded.
  - No result from before reset ever appears after reset.
  - o_ready is high on the first cycle after reset deasserts.
- Simultaneous events:
  - A full pipe with i_ready high accepts a new operand in the same cycle the oldest result leaves.
  - When reset is asserted together with i_valid, reset wins.

Test Plan:
- Latency and basic modes, WIDTH=8:
  - SLL 0x81 shamt 1 -> 0x02, 3 cycles after acceptance.
  - SRL 0x80 shamt 7 -> 0x01.
  - SRA 0x80 shamt 3 -> 0xF0.
  - ROL 0x81 shamt 1 -> 0x03.
  - SRA 0x70 shamt 4 -> 0x07.
- Zero flag:
  - SLL 0x80 shamt 1 -> o_out 0x00, o_zero 1.
  - SLL 0x01 shamt 0 -> o_out 0x01, o_zero 0.
- Backpressure:
  - Hold i_ready low, offer 5 back-to-back operands A..E -> exactly 3 accepted, then o_ready low.
  - Raise i_ready -> results A, B, C, then D, E, in order with none lost. o_out stable during the stall.
- Full streaming:
  - 16 random operands/modes with i_ready high -> one result per cycle from cycle 3.
  - Every result matches the reference model.
- Reset mid-stream:
  - Assert i_reset for 1 cycle with 3 operands in flight -> o_valid 0 and o_out 0 the next cycle.
  - No stale results afterwards. o_ready high after reset deasserts.
- Parameter sweep:
  - WIDTH=32, ROL 0x80000001 shamt 31 -> 0xC0000000 after 5 cycles.
  - Exhaustive shamt 0..31 in all modes against the model.

Source files
------------

// File: rtl/barrel_shifter_pipe.sv
// -----------------------------------------------------------------------------
// barrel_shifter_pipe
//
// Pipelined barrel shifter. Each stage resolves one bit of the shift amount,
// so an operand passes through SHW = log2(WIDTH) registered stages. A stage
// shifts by 2^k when its shift-amount bit is set, and passes the data through
// otherwise. Supported modes: logical left, logical right, arithmetic right
// and rotate left.
//
// Every stage has its own valid bit and load enable. Backpressure therefore
// ripples back one stage at a time. An empty stage always loads, which
// squeezes out bubbles, so the pipe can hold SHW operands while stalled.
//
// Parameters
//   WIDTH    data width, power of two, >= 2
//   SHW      derived: shift-amount width and pipeline depth
//
// Ports
//   i_clk     clock, rising edge
//   i_reset   synchronous active-high reset, flushes every stage
//   i_valid   operand valid          o_ready  operand can be accepted
//   i_in      operand                i_shamt  shift amount 0..WIDTH-1
//   i_mode    00 SLL, 01 SRL, 10 SRA, 11 ROL
//   o_valid   result valid           i_ready  downstream accepts result
//   o_out     shifted result         o_zero   o_out == 0, qualified by o_valid
// -----------------------------------------------------------------------------
module barrel_shifter_pipe #(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_in,
  input  logic [SHW-1:0]   i_shamt,
  input  logic [1:0]       i_mode,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_out,
  output logic             o_zero
);

  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRL = 2'b01;
  localparam logic [1:0] MODE_SRA = 2'b10;
  localparam logic [1:0] MODE_ROL = 2'b11;

  // Per-stage register contents, exported from each generate block so that
  // the following stage and the output ports can see them.
  logic             st_valid [SHW];
  logic [WIDTH-1:0] st_data  [SHW];
  logic [SHW-1:0]   st_shamt [SHW];
  logic [1:0]       st_mode  [SHW];
  logic             st_zero  [SHW];

  // load[k]: stage k captures its input this cycle.
  logic [SHW-1:0]   load;

  genvar gi;
  generate
    for (gi = 0; gi < SHW; gi++) begin : g_stage
      localparam int STEP = 1 << gi;

      logic             in_valid;
      logic [WIDTH-1:0] in_data;
      logic [SHW-1:0]   in_shamt;
      logic [1:0]       in_mode;
      logic [WIDTH-1:0] shifted;

      logic             valid_reg;
      logic [WIDTH-1:0] data_reg;
      logic [SHW-1:0]   shamt_reg;
      logic [1:0]       mode_reg;
      logic             zero_reg;

      // Stage 0 reads the input port. Its valid is the transfer condition,
      // so operands that are offered but not accepted never enter the pipe.
      if (gi == 0) begin : g_src
        assign in_valid = i_valid & o_ready;
        assign in_data  = i_in;
        assign in_shamt = i_shamt;
        assign in_mode  = i_mode;
      end else begin : g_src
        assign in_valid = st_valid[gi-1];
        assign in_data  = st_data[gi-1];
        assign in_shamt = st_shamt[gi-1];
        assign in_mode  = st_mode[gi-1];
      end

      // A stage may load when it is empty or its contents move on this
      // cycle. Evaluating emptiness per stage is what collapses bubbles.
      if (gi == SHW - 1) begin : g_load
        assign load[gi] = ~valid_reg | i_ready;
      end else begin : g_load
        assign load[gi] = ~valid_reg | load[gi+1];
      end

      // The remaining shift amount is stored right-justified, so bit 0 of
      // the incoming amount always selects this stage's shift of 2^gi.
      always_comb begin
        shifted = in_data;
        if (in_shamt[0]) begin
          case (in_mode)
            MODE_SLL: shifted = {in_data[WIDTH-STEP-1:0], {STEP{1'b0}}};
            MODE_SRL: shifted = {{STEP{1'b0}}, in_data[WIDTH-1:STEP]};
            // Replicating the current MSB keeps the original sign across
            // every later stage, so partial shifts compose correctly.
            MODE_SRA: shifted = {{STEP{in_data[WIDTH-1]}}, in_data[WIDTH-1:STEP]};
            MODE_ROL: shifted = {in_data[WIDTH-STEP-1:0], in_data[WIDTH-1:WIDTH-STEP]};
          endcase
        end
      end

      always_ff @(posedge i_clk) begin
        if (i_reset) begin
          valid_reg <= 1'b0;
          data_reg  <= '0;
          shamt_reg <= '0;
          mode_reg  <= MODE_SLL;
          zero_reg  <= 1'b0;
        end else if (load[gi]) begin
          valid_reg <= in_valid;
          data_reg  <= shifted;
          shamt_reg <= in_shamt >> 1;
          mode_reg  <= in_mode;
          zero_reg  <= ~|shifted;
        end
      end

      assign st_valid[gi] = valid_reg;
      assign st_data[gi]  = data_reg;
      assign st_shamt[gi] = shamt_reg;
      assign st_mode[gi]  = mode_reg;
      assign st_zero[gi]  = zero_reg;
    end
  endgenerate

  // The last stage's remaining amount and mode have no consumer. They are
  // kept so that every stage has the same register layout.
  logic unused_tail;
  assign unused_tail = ^{st_shamt[SHW-1], st_mode[SHW-1]};

  // Reset masks o_ready. This keeps an operand offered during reset from
  // looking accepted to upstream logic.
  assign o_ready = load[0] & ~i_reset;
  assign o_valid = st_valid[SHW-1];
  assign o_out   = st_data[SHW-1];
  assign o_zero  = st_zero[SHW-1];

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Testbench for barrel_shifter_pipe. It instantiates an 8-bit and a 32-bit
// copy. For each copy, a scoreboard queue receives the expected result when an
// operand is accepted. The entry is popped and compared when the result leaves.
module tb_barrel_shifter_pipe;

  localparam logic [1:0] SLL = 2'd0;
  localparam logic [1:0] SRL = 2'd1;
  localparam logic [1:0] SRA = 2'd2;
  localparam logic [1:0] ROL = 2'd3;

  typedef struct packed {
    logic [31:0] out;
    logic        zero;
    int          cyc;
    bit          lat;
  } exp_t;

  typedef struct packed {
    logic [7:0] din;
    logic [2:0] shamt;
    logic [1:0] mode;
    logic [7:0] dout;
    logic       zero;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec  = 0;
  int n_miss = 0;

  logic rst;

  // 8-bit DUT
  logic       v8, ordy8, ov8, ir8, z8;
  logic [7:0] in8, out8;
  logic [2:0] sh8;
  logic [1:0] md8;

  // 32-bit DUT
  logic        v32, ordy32, ov32, ir32, z32;
  logic [31:0] in32, out32;
  logic [4:0]  sh32;
  logic [1:0]  md32;

  barrel_shifter_pipe #(.WIDTH(8)) u_dut8 (
    .i_clk(clk), .i_reset(rst), .i_valid(v8), .o_ready(ordy8),
    .i_in(in8), .i_shamt(sh8), .i_mode(md8),
    .o_valid(ov8), .i_ready(ir8), .o_out(out8), .o_zero(z8)
  );

  barrel_shifter_pipe #(.WIDTH(32)) u_dut32 (
    .i_clk(clk), .i_reset(rst), .i_valid(v32), .o_ready(ordy32),
    .i_in(in32), .i_shamt(sh32), .i_mode(md32),
    .o_valid(ov32), .i_ready(ir32), .o_out(out32), .o_zero(z32)
  );

  // Reference: applies the whole shift in one step on a w-bit value.
  function automatic logic [31:0] model(int w, logic [31:0] d, int s, logic [1:0] m);
    logic [31:0] mask;
    logic [31:0] r;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    d = d & mask;
    case (m)
      SLL: r = (d << s) & mask;
      SRL: r = d >> s;
      SRA: begin
        r = d >> s;
        if (d[w-1]) r = r | (mask & ~(mask >> s));
      end
      default: r = (s == 0) ? d : (((d << s) | (d >> (w - s))) & mask);
    endcase
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- scoreboards ----------------
  exp_t q8[$], q32[$];
  exp_t nx8, nx32, e8, e32;
  logic       pstall8, pz8;
  logic [7:0] pout8;
  logic       pstall32;
  logic [31:0] pout32;

  always @(negedge clk) begin
    if (rst) begin
      q8.delete();
      pstall8 = 1'b0;
    end else begin
      if (pstall8) begin
        check("stall8_valid", 32'(ov8), 32'd1);
        check("stall8_out", 32'(out8), 32'(pout8));
        check("stall8_zero", 32'(z8), 32'(pz8));
      end
      if (ov8 && ir8) begin
        if (q8.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected8: got result %0h, expected none", out8);
        end else begin
          e8 = q8.pop_front();
          check("out8", 32'(out8), e8.out);
          check("zero8", 32'(z8), 32'(e8.zero));
          $display("w8  result %02h zero %0d (expected %02h)", out8, z8, e8.out[7:0]);
          if (e8.lat) check("lat8", 32'(cyc - e8.cyc), 32'd3);
        end
      end
      if (v8 && ordy8) begin
        nx8.cyc = cyc;
        q8.push_back(nx8);
      end
      pstall8 = ov8 && !ir8;
      pout8 = out8;
      pz8 = z8;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      q32.delete();
      pstall32 = 1'b0;
    end else begin
      if (pstall32) check("stall32_out", out32, pout32);
      if (ov32 && ir32) begin
        if (q32.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected32: got result %0h, expected none", out32);
        end else begin
          e32 = q32.pop_front();
          check("out32", out32, e32.out);
          check("zero32", 32'(z32), 32'(e32.zero));
          $display("w32 result %08h zero %0d (expected %08h)", out32, z32, e32.out);
          if (e32.lat) check("lat32", 32'(cyc - e32.cyc), 32'd5);
        end
      end
      if (v32 && ordy32) begin
        nx32.cyc = cyc;
        q32.push_back(nx32);
      end
      pstall32 = ov32 && !ir32;
      pout32 = out32;
    end
  end

  // ---------------- drivers ----------------
  task automatic put8(input logic [7:0] d, input logic [2:0] s, input logic [1:0] m, input bit lat);
    logic [7:0] e;
    e = model(8, 32'(d), int'(s), m)[7:0];
    v8 = 1'b1; in8 = d; sh8 = s; md8 = m;
    nx8 = '{out: 32'(e), zero: (e == 8'h00), cyc: 0, lat: lat};
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (ordy8) begin
        @(posedge clk); #1;
        return;
      end
    end
    n_vec++;
    n_miss++;
    $display("FAIL accept8_timeout: got no o_ready, expected acceptance of %02h", d);
  endtask

  task automatic put32(input logic [31:0] d, input logic [4:0] s, input logic [1:0] m, input bit lat);
    logic [31:0] e;
    e = model(32, d, int'(s), m);
    v32 = 1'b1; in32 = d; sh32 = s; md32 = m;
    nx32 = '{out: e, zero: (e == 32'h0), cyc: 0, lat: lat};
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (ordy32) begin
        @(posedge clk); #1;
        return;
      end
    end
    n_vec++;
    n_miss++;
    $display("FAIL accept32_timeout: got no o_ready, expected acceptance of %08h", d);
  endtask

  // Deassert valid and scramble the operand inputs; they must be ignored.
  task automatic idle8();
    v8 = 1'b0; in8 = 8'($urandom); sh8 = 3'($urandom); md8 = 2'($urandom);
  endtask

  task automatic drain8();
    for (int n = 0; n < 60; n++) begin
      @(posedge clk); #2;
      if (q8.size() == 0) return;
    end
    check("drain8_left", 32'(q8.size()), 32'd0);
  endtask

  task automatic drain32();
    for (int n = 0; n < 60; n++) begin
      @(posedge clk); #2;
      if (q32.size() == 0) return;
    end
    check("drain32_left", 32'(q32.size()), 32'd0);
  endtask

  vec_t tv[$];
  logic [7:0] bp_op[5];
  int accepted;
  int c0;
  bit acc;

  initial begin
    rst = 1'b1;
    v8 = 1'b0; in8 = '0; sh8 = '0; md8 = '0; ir8 = 1'b1;
    v32 = 1'b0; in32 = '0; sh32 = '0; md32 = '0; ir32 = 1'b1;
    nx8 = '0; nx32 = '0;

    // {in, shamt, mode, expected out, expected zero}
    tv.push_back('{8'h81, 3'd1, SLL, 8'h02, 1'b0});
    tv.push_back('{8'h80, 3'd7, SRL, 8'h01, 1'b0});
    tv.push_back('{8'h80, 3'd3, SRA, 8'hF0, 1'b0});
    tv.push_back('{8'h81, 3'd1, ROL, 8'h03, 1'b0});
    tv.push_back('{8'h70, 3'd4, SRA, 8'h07, 1'b0});
    tv.push_back('{8'h80, 3'd1, SLL, 8'h00, 1'b1});
    tv.push_back('{8'h01, 3'd0, SLL, 8'h01, 1'b0});
    tv.push_back('{8'h96, 3'd0, SRA, 8'h96, 1'b0});
    tv.push_back('{8'hA5, 3'd0, ROL, 8'hA5, 1'b0});
    tv.push_back('{8'h00, 3'd5, SRL, 8'h00, 1'b1});
    tv.push_back('{8'h81, 3'd7, ROL, 8'hC0, 1'b0});
    tv.push_back('{8'hFF, 3'd7, SRA, 8'hFF, 1'b0});
    tv.push_back('{8'h7F, 3'd7, SRA, 8'h00, 1'b1});
    tv.push_back('{8'hFF, 3'd7, SLL, 8'h80, 1'b0});
    tv.push_back('{8'hFF, 3'd4, SRL, 8'h0F, 1'b0});
    tv.push_back('{8'h12, 3'd4, ROL, 8'h21, 1'b0});

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid8", 32'(ov8), 32'd0);
    check("rst_out8", 32'(out8), 32'd0);
    check("rst_zero8", 32'(z8), 32'd0);
    check("rst_ready8", 32'(ordy8), 32'd0);
    check("rst_valid32", 32'(ov32), 32'd0);
    check("rst_zero32", 32'(z32), 32'd0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", 32'(ordy8), 32'd1);

    // Table: isolated operands, latency checked by the scoreboard.
    foreach (tv[i]) begin
      v8 = 1'b1; in8 = tv[i].din; sh8 = tv[i].shamt; md8 = tv[i].mode;
      nx8 = '{out: 32'(tv[i].dout), zero: tv[i].zero, cyc: 0, lat: 1'b1};
      for (int n = 0; n < 20 && !ordy8; n++) @(posedge clk);
      @(posedge clk); #1;
      idle8();
      drain8();
    end

    // Backpressure: with i_ready low, only three operands fit.
    ir8 = 1'b0;
    for (int i = 0; i < 5; i++) bp_op[i] = 8'($urandom);
    accepted = 0;
    for (int c = 0; c < 6; c++) begin
      v8 = 1'b1;
      in8 = bp_op[accepted]; sh8 = 3'(accepted + 1); md8 = 2'(accepted);
      nx8 = '{out: model(8, 32'(bp_op[accepted]), accepted + 1, 2'(accepted)),
              zero: (model(8, 32'(bp_op[accepted]), accepted + 1, 2'(accepted)) == 0),
              cyc: 0, lat: 1'b0};
      @(negedge clk);
      acc = ordy8;
      @(posedge clk); #1;
      if (acc) accepted++;
    end
    check("bp_accepted", 32'(accepted), 32'd3);
    check("bp_ready_low", 32'(ordy8), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    ir8 = 1'b1;
    #1;
    check("bp_full_accept", 32'(ordy8), 32'd1);
    for (int i = 3; i < 5; i++) put8(bp_op[i], 3'(i + 1), 2'(i), 1'b0);
    idle8();
    drain8();

    // Full-rate streaming.
    c0 = cyc;
    for (int i = 0; i < 16; i++) put8(8'($urandom), 3'($urandom), 2'($urandom), 1'b1);
    check("stream_rate", 32'(cyc - c0), 32'd16);
    idle8();
    drain8();

    // Reset with three operands in flight, plus a fourth offered during reset.
    for (int i = 0; i < 3; i++) put8(8'hFF - 8'(i), 3'(i), SRL, 1'b1);
    v8 = 1'b1; in8 = 8'h55; sh8 = 3'd2; md8 = ROL;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle8();
    #1;
    check("midrst_valid", 32'(ov8), 32'd0);
    check("midrst_out", 32'(out8), 32'd0);
    check("midrst_zero", 32'(z8), 32'd0);
    check("midrst_ready", 32'(ordy8), 32'd1);
    repeat (8) @(posedge clk);
    #1;
    put8(8'h3C, 3'd2, SLL, 1'b1);
    idle8();
    drain8();

    // 32-bit instance: corner case, then every shift amount in every mode.
    put32(32'h8000_0001, 5'd31, ROL, 1'b1);
    v32 = 1'b0;
    drain32();
    for (int m = 0; m < 4; m++)
      for (int s = 0; s < 32; s++)
        put32((s % 3 == 0) ? 32'h8000_0001 : $urandom, 5'(s), 2'(m), 1'b1);
    v32 = 1'b0;
    drain32();

    check("final_q8", 32'(q8.size()), 32'd0);
    check("final_q32", 32'(q32.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
